dbg_probe_scan: RTL and testbench
=================================

// Module: dbg_probe_scan
// PURPOSE
//  Parametrised debug readout unit for the CPU. It selects one of NCH internal probe words (pc, ir, alu
//  operands/result, regfile ports, ...) for the board display or debug link. Supports live select,
//  whole-bus snapshot freeze and an auto-scan mode that streams every channel over a valid/ready handshake.
//  Sits between the datapath probe taps and the display/UART debug front end.
// PARAMETERS
//  WIDTH     16    probe word width (bits)
//  NCH       16    number of probe channels (2..64)
//  SEL_W     6     channel-select width; NCH <= 2**SEL_W
//  SCAN_DIV  4     clocks between scan words after each accept (>=1)
// PORTS
//  clk        in   1            system clock, rising edge
//  rst_n      in   1            asynchronous active-low reset
//  probe_bus  in   NCH*WIDTH    channel k = probe_bus[k*WIDTH +: WIDTH]
//  mode       in   2            00 LIVE, 01 SNAP, 10 SCAN, 11 OFF
//  sel        in   SEL_W        channel select for LIVE/SNAP
//  snap_req   in   1            pulse: freeze all channels into the snapshot buffer
//  snap_done  out  1            one-cycle pulse, the cycle after capture
//  out_data   out  WIDTH        selected/streamed word (registered)
//  out_chan   out  SEL_W        channel index of out_data
//  out_valid  out  1            SCAN only: out_data/out_chan valid
//  out_ready  in   1            consumer accepts when out_valid & out_ready
//  scan_wrap  out  1            one-cycle pulse when channel NCH-1 is accepted
// BEHAVIOUR
//  Reset: all outputs 0, snapshot buffer 0, scan FSM IDLE, scan index 0, divider 0.
//  LIVE: out_data <= probe[sel] each clock, 1-cycle latency; out_chan <= sel; out_valid=0.
//  SNAP: out_data <= snap[sel], out_chan <= sel, 1-cycle latency; out_valid=0.
//  snap_req (any mode): all NCH words captured on that edge; snap_done=1 next cycle.
//   snap_req on consecutive cycles: each one recaptures and pulses.
//  sel >= NCH (LIVE/SNAP): out_data <= 0, out_chan <= sel.
//  OFF: out_data, out_chan, out_valid <= 0; snapshot is kept.
//  SCAN FSM (states IDLE, WAITDIV, PRESENT):
//   IDLE -> WAITDIV on mode==10; divider cleared; idx=0.
//   WAITDIV: divider counts 0..SCAN_DIV-1; at SCAN_DIV-1 latch probe[idx] into out_data,
//    out_chan<=idx, out_valid<=1 -> PRESENT.
//   PRESENT: out_data/out_chan stable while out_valid & !out_ready.
//    On accept: out_valid<=0, idx<=(idx==NCH-1)?0:idx+1, scan_wrap pulses if idx==NCH-1,
//    -> WAITDIV.
//   Leaving mode 10 in any state: next edge out_valid<=0, FSM->IDLE, idx<=0, no scan_wrap.
//   Re-entry always restarts at channel 0.
//  Scan words are live values sampled at latch time and are not read from the snapshot.
//  Back-to-back accept plus mode change: the accept completes and the exit takes priority for the next state.
//  All arithmetic is unsigned. The divider and idx are sized $clog2 of their range, with no overflow past wrap.
// CONFIGURATION
//  PROBE_PARITY_EN defined: extra output out_par (1 bit) = even parity (^out_data), registered with out_data.
//   Reset 0.
//  Not defined: the out_par port does not exist and no parity logic is built.
// STRUCTURE
//  Shared package dbg_pkg: mode encodings (MODE_LIVE/SNAP/SCAN/OFF) and scan state encodings.
//  Sub-module dbg_snap_buf: NCH x WIDTH capture register array with a read mux.
//  Top module holds the mode mux, divider and scan FSM.
// TESTING
//  1 Reset mid-scan with out_valid=1: rst_n low -> out_valid=0, out_data=0, idx=0; asynchronous, no clk needed.
//  2 LIVE, NCH=16, ch3=16'h1234, sel=3 -> out_data=16'h1234, out_chan=3 one clk later; sel=20 -> 0.
//  3 SNAP: ch5=16'hAAAA, pulse snap_req, then ch5=16'h5555, sel=5 -> out_data stays 16'hAAAA;
//    snap_done high exactly 1 cycle.
//  4 SCAN, SCAN_DIV=4, out_ready=1 -> words on channels 0,1,..,15,0 spaced 5 clks;
//    scan_wrap pulses once at channel 15 accept.
//  5 SCAN backpressure: out_ready=0 for 10 clks on channel 2 -> data/chan stable, valid held;
//    ready=1 -> next word is channel 3.
//  6 Mode 10->00 while PRESENT on channel 7 -> out_valid=0 next clk; back to 10 -> first word is channel 0.
//    With PROBE_PARITY_EN, out_par = ^out_data on every word.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared encodings for the debug probe readout unit: operating modes and
// auto-scan FSM states.
package dbg_pkg;

   // Operating mode, driven on the 2-bit mode input.
   typedef enum logic [1:0] {
      MODE_LIVE = 2'b00,
      MODE_SNAP = 2'b01,
      MODE_SCAN = 2'b10,
      MODE_OFF  = 2'b11
   } mode_e;

   // Auto-scan FSM states.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_WAITDIV = 2'b01,
      ST_PRESENT = 2'b10
   } scan_state_e;

endpackage : dbg_pkg

// File: rtl/dbg_probe_scan_if.sv
// Readout-side interface of dbg_probe_scan: streamed/selected word, its
// channel index, the scan handshake and the wrap pulse.
// Optional feature macro: PROBE_PARITY_EN adds out_par (even parity of out_data).
//
// Handshake: out_valid is raised only in SCAN mode. While out_valid is high,
// out_data/out_chan stay stable. A word is transferred on a rising clk edge
// where out_valid & out_ready are both high; out_valid drops on that edge.
// out_ready may be held high permanently; it never needs to wait for valid.
interface dbg_probe_scan_if #(
   parameter int WIDTH = 16,
   parameter int SEL_W = 6
);
   logic [WIDTH-1:0] out_data;
   logic [SEL_W-1:0] out_chan;
   logic             out_valid;
   logic             out_ready;
   logic             scan_wrap;
`ifdef PROBE_PARITY_EN
   logic             out_par;

   modport master (
      output out_data, out_chan, out_valid, scan_wrap, out_par,
      input  out_ready
   );
   modport slave (
      input  out_data, out_chan, out_valid, scan_wrap, out_par,
      output out_ready
   );
`else
   modport master (
      output out_data, out_chan, out_valid, scan_wrap,
      input  out_ready
   );
   modport slave (
      input  out_data, out_chan, out_valid, scan_wrap,
      output out_ready
   );
`endif
endinterface : dbg_probe_scan_if

// File: rtl/dbg_snap_buf.sv
// Snapshot buffer: NCH x WIDTH capture registers loaded all at once on a
// capture pulse, with a combinational read mux (out-of-range select reads 0).
module dbg_snap_buf #(
   parameter int WIDTH = 16,
   parameter int NCH   = 16,
   parameter int SEL_W = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 capture,
   input  logic [NCH*WIDTH-1:0] probe_bus,
   input  logic [SEL_W-1:0]     rd_sel,
   output logic [WIDTH-1:0]     rd_data
);

   logic [NCH*WIDTH-1:0] snap_q, snap_d;

   // Load the whole probe bus when capture is asserted, otherwise hold.
   always_comb begin
      snap_d = snap_q;
      if (capture) snap_d = probe_bus;
   end

   // Snapshot register array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) snap_q <= '0;
      else        snap_q <= snap_d;
   end

   // Read mux; selects at or beyond NCH fall through to zero.
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < NCH; k++) begin
         if (rd_sel == SEL_W'(k)) rd_data = snap_q[k*WIDTH +: WIDTH];
      end
   end

endmodule : dbg_snap_buf

// File: rtl/dbg_probe_scan.sv
// Debug probe readout unit: picks one of NCH probe words (live or from a
// frozen snapshot) or streams all channels in turn over a valid/ready link.
// Optional feature macro: PROBE_PARITY_EN adds out_par = ^out_data, registered
// alongside out_data.
// dbg_state / dbg_idx expose the scan FSM state and channel index.
module dbg_probe_scan
   import dbg_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int NCH      = 16,
   parameter int SEL_W    = 6,
   parameter int SCAN_DIV = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH*WIDTH-1:0] probe_bus,
   input  logic [1:0]           mode,
   input  logic [SEL_W-1:0]     sel,
   input  logic                 snap_req,
   output logic                 snap_done,
   dbg_probe_scan_if.master     out_if,
   output scan_state_e          dbg_state,
   output logic [SEL_W-1:0]     dbg_idx
);

   localparam int IDX_W = $clog2(NCH);
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   scan_state_e      state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SEL_W-1:0] chan_q, chan_d;
   logic             valid_q, valid_d;
   logic             wrap_q, wrap_d;
   logic             snap_done_q, snap_done_d;
   logic [WIDTH-1:0] live_word;
   logic [WIDTH-1:0] scan_word;
   logic [WIDTH-1:0] snap_word;

   dbg_snap_buf #(
      .WIDTH (WIDTH),
      .NCH   (NCH),
      .SEL_W (SEL_W)
   ) u_snap_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .capture   (snap_req),
      .probe_bus (probe_bus),
      .rd_sel    (sel),
      .rd_data   (snap_word)
   );

   // Live-select and scan-index read muxes straight off the probe bus.
   always_comb begin
      live_word = '0;
      scan_word = '0;
      for (int k = 0; k < NCH; k++) begin
         if (sel == SEL_W'(k))   live_word = probe_bus[k*WIDTH +: WIDTH];
         if (idx_q == IDX_W'(k)) scan_word = probe_bus[k*WIDTH +: WIDTH];
      end
   end

   // Mode mux and scan FSM next-state; leaving SCAN always returns the FSM
   // to IDLE at channel 0 without a wrap pulse, even if an accept coincides.
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      idx_d       = idx_q;
      data_d      = data_q;
      chan_d      = chan_q;
      valid_d     = valid_q;
      wrap_d      = 1'b0;
      snap_done_d = snap_req;

      case (mode)
         MODE_LIVE: begin
            data_d  = live_word;
            chan_d  = sel;
            valid_d = 1'b0;
         end
         MODE_SNAP: begin
            data_d  = snap_word;
            chan_d  = sel;
            valid_d = 1'b0;
         end
         MODE_SCAN: begin
            case (state_q)
               ST_IDLE: begin
                  state_d = ST_WAITDIV;
                  div_d   = '0;
                  idx_d   = '0;
                  valid_d = 1'b0;
               end
               ST_WAITDIV: begin
                  if (div_q == DIV_W'(SCAN_DIV - 1)) begin
                     data_d  = scan_word;
                     chan_d  = SEL_W'(idx_q);
                     valid_d = 1'b1;
                     div_d   = '0;
                     state_d = ST_PRESENT;
                  end else begin
                     div_d = div_q + DIV_W'(1);
                  end
               end
               ST_PRESENT: begin
                  if (out_if.out_ready) begin
                     valid_d = 1'b0;
                     div_d   = '0;
                     state_d = ST_WAITDIV;
                     if (idx_q == IDX_W'(NCH - 1)) begin
                        idx_d  = '0;
                        wrap_d = 1'b1;
                     end else begin
                        idx_d = idx_q + IDX_W'(1);
                     end
                  end
               end
               default: begin
                  state_d = ST_IDLE;
                  div_d   = '0;
                  idx_d   = '0;
                  valid_d = 1'b0;
               end
            endcase
         end
         default: begin
            data_d  = '0;
            chan_d  = '0;
            valid_d = 1'b0;
         end
      endcase

      if (mode != MODE_SCAN) begin
         state_d = ST_IDLE;
         div_d   = '0;
         idx_d   = '0;
      end
   end

   // Output, FSM and handshake registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         div_q       <= '0;
         idx_q       <= '0;
         data_q      <= '0;
         chan_q      <= '0;
         valid_q     <= 1'b0;
         wrap_q      <= 1'b0;
         snap_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         idx_q       <= idx_d;
         data_q      <= data_d;
         chan_q      <= chan_d;
         valid_q     <= valid_d;
         wrap_q      <= wrap_d;
         snap_done_q <= snap_done_d;
      end
   end

`ifdef PROBE_PARITY_EN
   logic par_q, par_d;

   // Even parity of the word being loaded into out_data.
   always_comb begin
      par_d = ^data_d;
   end

   // Parity register, updated in step with out_data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par_q <= 1'b0;
      else        par_q <= par_d;
   end

   assign out_if.out_par = par_q;
`endif

   assign out_if.out_data  = data_q;
   assign out_if.out_chan  = chan_q;
   assign out_if.out_valid = valid_q;
   assign out_if.scan_wrap = wrap_q;
   assign snap_done        = snap_done_q;
   assign dbg_state        = state_q;
   assign dbg_idx          = SEL_W'(idx_q);

endmodule : dbg_probe_scan

// File: tb/tb_dbg_probe_scan.sv
// Directed bench for dbg_probe_scan: LIVE/SNAP/OFF readout, scan streaming,
// backpressure, scan exit/re-entry and asynchronous reset mid-scan.
module tb_dbg_probe_scan;
  import dbg_pkg::*;

  localparam int WIDTH    = 16;
  localparam int NCH      = 16;
  localparam int SEL_W    = 6;
  localparam int SCAN_DIV = 4;
  localparam int EW       = SEL_W + WIDTH;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [NCH*WIDTH-1:0] probe_bus;
  logic [1:0]           mode;
  logic [SEL_W-1:0]     sel;
  logic                 snap_req;
  logic                 snap_done;
  scan_state_e          dbg_state;
  logic [SEL_W-1:0]     dbg_idx;

  dbg_probe_scan_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) tb_if ();

  dbg_probe_scan #(
    .WIDTH    (WIDTH),
    .NCH      (NCH),
    .SEL_W    (SEL_W),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .probe_bus (probe_bus),
    .mode      (mode),
    .sel       (sel),
    .snap_req  (snap_req),
    .snap_done (snap_done),
    .out_if    (tb_if),
    .dbg_state (dbg_state),
    .dbg_idx   (dbg_idx)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]    exp_q[$];
  logic [WIDTH-1:0] probe_m [NCH];
  int tests    = 0;
  int fails    = 0;
  int wrap_cnt = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (tb_if.scan_wrap === 1'b1) wrap_cnt++;
  endtask

  task automatic drive_probes();
    for (int k = 0; k < NCH; k++) probe_bus[k*WIDTH +: WIDTH] = probe_m[k];
  endtask

  task automatic push_exp(input int ch, input logic [WIDTH-1:0] val);
    exp_q.push_back({SEL_W'(ch), val});
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s observed=%0h expected=queued-entry", tag, {tb_if.out_chan, tb_if.out_data});
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'({tb_if.out_chan, tb_if.out_data}), 32'(e));
`ifdef PROBE_PARITY_EN
      check({tag, "_par"}, 32'(tb_if.out_par), 32'(^e[WIDTH-1:0]));
`endif
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (tb_if.out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (tb_if.out_valid !== 1'b1) begin
      tests++;
      fails++;
      $error("FAIL %s observed=no-valid expected=valid within 40 clks", tag);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int last_cyc;
    int prev_chan;

    rst_n           = 1'b0;
    mode            = MODE_LIVE;
    sel             = '0;
    snap_req        = 1'b0;
    tb_if.out_ready = 1'b0;
    for (int k = 0; k < NCH; k++) probe_m[k] = 16'h1000 + WIDTH'(k) * 16'h0111;
    drive_probes();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_data",  32'(tb_if.out_data),  32'h0);
    check("rst_chan",  32'(tb_if.out_chan),  32'h0);
    check("rst_valid", 32'(tb_if.out_valid), 32'h0);
    check("rst_wrap",  32'(tb_if.scan_wrap), 32'h0);
    check("rst_sdone", 32'(snap_done),       32'h0);
    check("rst_state", 32'(dbg_state),       32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // LIVE: directed select, out-of-range select, random selects
    probe_m[3] = 16'h1234;
    drive_probes();
    sel = 6'd3;
    push_exp(3, 16'h1234);
    tick();
    pop_check("live_ch3");
    check("live_valid", 32'(tb_if.out_valid), 32'h0);
    sel = 6'd20;
    push_exp(20, '0);
    tick();
    pop_check("live_oob");
    for (int k = 0; k < NCH; k++) probe_m[k] = WIDTH'($urandom_range(0, 16'hFFFF));
    drive_probes();
    for (int i = 0; i < 6; i++) begin
      int s;
      s   = $urandom_range(0, NCH - 1);
      sel = SEL_W'(s);
      push_exp(s, probe_m[s]);
      tick();
      pop_check("live_rand");
    end

    // SNAP: capture, then live value changes but readout keeps the capture
    probe_m[5] = 16'hAAAA;
    drive_probes();
    snap_req = 1'b1;
    tick();
    check("snap_done_hi", 32'(snap_done), 32'h1);
    snap_req   = 1'b0;
    probe_m[5] = 16'h5555;
    drive_probes();
    mode = MODE_SNAP;
    sel  = 6'd5;
    push_exp(5, 16'hAAAA);
    tick();
    check("snap_done_lo", 32'(snap_done), 32'h0);
    pop_check("snap_frozen");

    // Back-to-back snap requests each recapture and pulse
    snap_req = 1'b1;
    tick();
    check("snap_b2b_1", 32'(snap_done), 32'h1);
    probe_m[5] = 16'h7777;
    drive_probes();
    tick();
    check("snap_b2b_2", 32'(snap_done), 32'h1);
    snap_req = 1'b0;
    push_exp(5, 16'h7777);
    tick();
    check("snap_b2b_end", 32'(snap_done), 32'h0);
    pop_check("snap_recapture");
    sel = 6'd40;
    push_exp(40, '0);
    tick();
    pop_check("snap_oob");

    // OFF clears outputs, snapshot survives
    mode = MODE_OFF;
    tick();
    check("off_data",  32'(tb_if.out_data),  32'h0);
    check("off_chan",  32'(tb_if.out_chan),  32'h0);
    check("off_valid", 32'(tb_if.out_valid), 32'h0);
    mode = MODE_SNAP;
    sel  = 6'd5;
    push_exp(5, 16'h7777);
    tick();
    pop_check("snap_kept");

    // SCAN with ready held high: 0..15 then 0, 5 clocks apart, one wrap
    mode = MODE_OFF;
    tick();
    for (int k = 0; k < NCH; k++) probe_m[k] = 16'h1000 + WIDTH'(k) * 16'h0111;
    drive_probes();
    for (int k = 0; k <= NCH; k++) push_exp(k % NCH, probe_m[k % NCH]);
    wrap_cnt        = 0;
    tb_if.out_ready = 1'b1;
    mode            = MODE_SCAN;
    wait_valid("scan_first");
    last_cyc  = cyc;
    prev_chan = int'(tb_if.out_chan);
    pop_check("scan_word");
    for (int i = 1; i <= NCH; i++) begin
      tick();
      if (prev_chan == NCH - 1) check("scan_wrap_pulse", 32'(tb_if.scan_wrap), 32'h1);
      wait_valid("scan_next");
      check("scan_spacing", 32'(cyc - last_cyc), 32'(SCAN_DIV + 1));
      last_cyc  = cyc;
      prev_chan = int'(tb_if.out_chan);
      pop_check("scan_word");
    end
    check("scan_wrap_count", 32'(wrap_cnt), 32'h1);

    // SCAN backpressure on channel 2
    mode = MODE_OFF;
    tick();
    exp_q.delete();
    for (int k = 0; k < 4; k++) push_exp(k, probe_m[k]);
    tb_if.out_ready = 1'b1;
    mode            = MODE_SCAN;
    wait_valid("bp_w0");
    pop_check("bp_ch0");
    tick();
    wait_valid("bp_w1");
    pop_check("bp_ch1");
    tick();
    tb_if.out_ready = 1'b0;
    wait_valid("bp_w2");
    pop_check("bp_ch2");
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", 32'(tb_if.out_valid), 32'h1);
      check("bp_hold_word", 32'({tb_if.out_chan, tb_if.out_data}), 32'({SEL_W'(2), probe_m[2]}));
    end
    tb_if.out_ready = 1'b1;
    tick();
    check("bp_accept_drop", 32'(tb_if.out_valid), 32'h0);
    wait_valid("bp_w3");
    pop_check("bp_ch3");

    // Exit SCAN while presenting channel 7, then re-enter at channel 0
    mode = MODE_OFF;
    tick();
    exp_q.delete();
    for (int k = 0; k < 8; k++) push_exp(k, probe_m[k]);
    tb_if.out_ready = 1'b1;
    mode            = MODE_SCAN;
    for (int k = 0; k < 7; k++) begin
      wait_valid("exit_wk");
      pop_check("exit_pre");
      tick();
    end
    tb_if.out_ready = 1'b0;
    wait_valid("exit_w7");
    pop_check("exit_ch7");
    check("exit_state_present", 32'(dbg_state), 32'(ST_PRESENT));
    mode = MODE_LIVE;
    sel  = 6'd1;
    push_exp(1, probe_m[1]);
    tick();
    check("exit_valid", 32'(tb_if.out_valid), 32'h0);
    check("exit_state", 32'(dbg_state),       32'(ST_IDLE));
    check("exit_idx",   32'(dbg_idx),         32'h0);
    check("exit_wrap",  32'(tb_if.scan_wrap), 32'h0);
    pop_check("exit_live");
    push_exp(0, probe_m[0]);
    mode = MODE_SCAN;
    tick();
    wait_valid("reentry_w");
    pop_check("reentry_ch0");

    // Asynchronous reset while a word is presented
    check("mid_valid", 32'(tb_if.out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(tb_if.out_valid), 32'h0);
    check("arst_data",  32'(tb_if.out_data),  32'h0);
    check("arst_idx",   32'(dbg_idx),         32'h0);
    check("arst_state", 32'(dbg_state),       32'(ST_IDLE));
    mode = MODE_LIVE;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_dbg_probe_scan
